// File: rtl/sram_arbiter.sv
//==============================================================================
// Module   : sram_arbiter
// Purpose  : N-port arbiter in front of a single-access SRAM controller.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int N_PORTS     = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PORTS-1:0]           port_en,
    input  logic [N_PORTS-1:0]           req,
    input  logic [N_PORTS-1:0]           req_we,
    input  logic [N_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [N_PORTS*DATA_W-1:0]    req_wdata,
    output logic [N_PORTS-1:0]           done,
    output logic [N_PORTS-1:0]           err,
    output logic [DATA_W-1:0]            rdata,
    output logic [$clog2(N_PORTS)-1:0]   grant_idx,
    output logic                         busy,
    output logic [ADDR_W-1:0]            address,
    output logic [DATA_W-1:0]            data_write,
    output logic                         read,
    output logic                         write,
    input  logic [DATA_W-1:0]            data_read,
    input  logic                         ready
);

    localparam int                 c_idx_w     = $clog2(N_PORTS);
    localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(N_PORTS - 1);
    localparam logic [7:0]         c_timeout   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_last;
    logic [7:0]           r_cnt;
    logic                 r_we;

    logic [N_PORTS-1:0]   w_elig;
    logic                 w_found;
    int                   w_idx;
    int                   w_sel;

    // Winner search: rotating start after the last grant, or index 0 for fixed priority.
    always_comb begin
        w_elig  = req & port_en;
        w_found = 1'b0;
        w_idx   = 0;
        w_sel   = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (ROUND_ROBIN != 0)
                w_idx = (int'(r_last) + 1 + i) % N_PORTS;
            else
                w_idx = i;
            if (!w_found && w_elig[c_idx_w'(w_idx)]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last     <= c_last_init;
            r_cnt      <= 8'd0;
            r_we       <= 1'b0;
            done       <= '0;
            err        <= '0;
            rdata      <= '0;
            grant_idx  <= '0;
            busy       <= 1'b0;
            address    <= '0;
            data_write <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        grant_idx  <= c_idx_w'(w_sel);
                        r_last     <= c_idx_w'(w_sel);
                        address    <= req_addr[w_sel*ADDR_W +: ADDR_W];
                        data_write <= req_wdata[w_sel*DATA_W +: DATA_W];
                        r_we       <= req_we[c_idx_w'(w_sel)];
                        read       <= ~req_we[c_idx_w'(w_sel)];
                        write      <= req_we[c_idx_w'(w_sel)];
                        busy       <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    read    <= 1'b0;
                    write   <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // ready outranks a timeout landing on the same cycle
                    if (ready) begin
                        done[grant_idx] <= 1'b1;
                        if (!r_we)
                            rdata <= data_read;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt + 8'd1 == c_timeout) begin
                        err[grant_idx] <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    read    <= 1'b0;
                    write   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
//==============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed self-checking bench: round-robin and fixed-priority arbiters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // three-port round-robin instance with a short timeout
    logic [2:0]      rr_en, rr_req, rr_we, rr_done, rr_err;
    logic [3*AW-1:0] rr_addr;
    logic [3*DW-1:0] rr_wdata;
    logic [DW-1:0]   rr_rdata, rr_dw, rr_dr;
    logic [1:0]      rr_gnt;
    logic            rr_busy, rr_rd, rr_wr, rr_ready;
    logic [AW-1:0]   rr_address;

    // two-port fixed-priority instance
    logic [1:0]      fp_en, fp_req, fp_we, fp_done, fp_err;
    logic [2*AW-1:0] fp_addr;
    logic [2*DW-1:0] fp_wdata;
    logic [DW-1:0]   fp_rdata, fp_dw, fp_dr;
    logic [0:0]      fp_gnt;
    logic            fp_busy, fp_rd, fp_wr, fp_ready;
    logic [AW-1:0]   fp_address;

    sram_arbiter #(.N_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .reset(reset), .port_en(rr_en), .req(rr_req), .req_we(rr_we),
        .req_addr(rr_addr), .req_wdata(rr_wdata), .done(rr_done), .err(rr_err),
        .rdata(rr_rdata), .grant_idx(rr_gnt), .busy(rr_busy), .address(rr_address),
        .data_write(rr_dw), .read(rr_rd), .write(rr_wr), .data_read(rr_dr), .ready(rr_ready)
    );

    sram_arbiter #(.N_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0), .TIMEOUT(255)) u_fp (
        .clk(clk), .reset(reset), .port_en(fp_en), .req(fp_req), .req_we(fp_we),
        .req_addr(fp_addr), .req_wdata(fp_wdata), .done(fp_done), .err(fp_err),
        .rdata(fp_rdata), .grant_idx(fp_gnt), .busy(fp_busy), .address(fp_address),
        .data_write(fp_dw), .read(fp_rd), .write(fp_wr), .data_read(fp_dr), .ready(fp_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rr_en    = 3'b111; rr_req = '0; rr_we = '0; rr_addr = '0; rr_wdata = '0;
        rr_dr    = '0;     rr_ready = 1'b0;
        fp_en    = 2'b00;  fp_req = '0; fp_we = '0; fp_addr = '0; fp_wdata = '0;
        fp_dr    = '0;     fp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_busy", rr_busy, 0);
        check_eq("rst_gnt", rr_gnt, 0);
        check_eq("rst_rdata", rr_rdata, 0);
        check_eq("rst_done", rr_done, 0);
        check_eq("rst_addr", rr_address, 0);
        check_eq("rst_read", rr_rd, 0);
        check_eq("rst_fp_gnt", fp_gnt, 0);
        reset = 1'b0;

        // single read on port 1, ready two cycles after ISSUE
        rr_req = 3'b010;
        rr_addr[1*AW +: AW] = 18'h00010;
        tick();
        check_eq("rd_read", rr_rd, 1);
        check_eq("rd_write", rr_wr, 0);
        check_eq("rd_gnt", rr_gnt, 1);
        check_eq("rd_addr", rr_address, 18'h00010);
        check_eq("rd_busy", rr_busy, 1);
        tick();
        check_eq("rd_read_1cyc", rr_rd, 0);
        tick();
        check_eq("rd_done_early", rr_done, 0);
        rr_ready = 1'b1; rr_dr = 16'hBEEF;
        tick();
        check_eq("rd_done", rr_done, 3'b010);
        check_eq("rd_rdata", rr_rdata, 16'hBEEF);
        check_eq("rd_idle", rr_busy, 0);
        rr_req = '0; rr_ready = 1'b0;
        tick();
        check_eq("rd_done_pulse", rr_done, 0);
        rr_ready = 1'b1;
        tick();
        check_eq("idle_ready_busy", rr_busy, 0);
        check_eq("idle_ready_done", rr_done, 0);
        rr_ready = 1'b0;

        // timeout: port 0 read, no ready
        rr_req = 3'b001;
        rr_addr[0 +: AW] = 18'h00ABC;
        tick();
        check_eq("to_gnt", rr_gnt, 0);
        repeat (4) tick();
        check_eq("to_err_early", rr_err, 0);
        check_eq("to_busy", rr_busy, 1);
        tick();
        check_eq("to_err", rr_err, 3'b001);
        check_eq("to_done", rr_done, 0);
        check_eq("to_idle", rr_busy, 0);
        check_eq("to_rdata", rr_rdata, 16'hBEEF);
        rr_req = '0;
        tick();
        check_eq("to_err_pulse", rr_err, 0);

        // ready on the timeout cycle wins
        rr_req = 3'b001;
        repeat (5) tick();
        check_eq("tr_busy", rr_busy, 1);
        rr_ready = 1'b1; rr_dr = 16'h5A5A;
        tick();
        check_eq("tr_done", rr_done, 3'b001);
        check_eq("tr_err", rr_err, 0);
        check_eq("tr_rdata", rr_rdata, 16'h5A5A);
        rr_req = '0; rr_ready = 1'b0;
        tick();

        // async reset during WAIT of a port-2 write
        rr_req = 3'b100; rr_we = 3'b100;
        rr_addr[2*AW +: AW] = 18'h2AAAA;
        rr_wdata[2*DW +: DW] = 16'h7777;
        tick();
        check_eq("rs_gnt", rr_gnt, 2);
        check_eq("rs_write", rr_wr, 1);
        check_eq("rs_read", rr_rd, 0);
        check_eq("rs_dw", rr_dw, 16'h7777);
        tick();
        #2 reset = 1'b1;
        #1;
        check_eq("rs_busy", rr_busy, 0);
        check_eq("rs_wr0", rr_wr, 0);
        check_eq("rs_rd0", rr_rd, 0);
        check_eq("rs_done", rr_done, 0);
        check_eq("rs_err", rr_err, 0);
        check_eq("rs_gnt0", rr_gnt, 0);
        check_eq("rs_addr0", rr_address, 0);
        check_eq("rs_rdata0", rr_rdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // round-robin fairness: all ports, ready always high
        rr_req = 3'b111; rr_we = 3'b000; rr_ready = 1'b1; rr_dr = 16'hC0DE;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("rr_gnt%0d", k), rr_gnt, k % 3);
            check_eq($sformatf("rr_read%0d", k), rr_rd, 1);
            tick();
            tick();
            check_eq($sformatf("rr_done%0d", k), rr_done, 3'b001 << (k % 3));
            check_eq($sformatf("rr_rdata%0d", k), rr_rdata, 16'hC0DE);
        end
        rr_req = '0; rr_ready = 1'b0;
        tick();

        // write then read of the top address
        rr_req = 3'b001; rr_we = 3'b001;
        rr_addr[0 +: AW] = 18'h3FFFF;
        rr_wdata[0 +: DW] = 16'h1234;
        rr_dr = 16'hFFFF;
        tick();
        check_eq("wr_gnt", rr_gnt, 0);
        check_eq("wr_write", rr_wr, 1);
        check_eq("wr_read", rr_rd, 0);
        check_eq("wr_addr", rr_address, 18'h3FFFF);
        check_eq("wr_dw", rr_dw, 16'h1234);
        tick();
        check_eq("wr_dw_hold", rr_dw, 16'h1234);
        check_eq("wr_write_1cyc", rr_wr, 0);
        rr_ready = 1'b1;
        tick();
        check_eq("wr_done", rr_done, 3'b001);
        check_eq("wr_rdata_kept", rr_rdata, 16'hC0DE);
        rr_ready = 1'b0; rr_we = '0;
        rr_req = 3'b010;
        rr_addr[1*AW +: AW] = 18'h3FFFF;
        tick();
        check_eq("rb_gnt", rr_gnt, 1);
        check_eq("rb_read", rr_rd, 1);
        check_eq("rb_addr", rr_address, 18'h3FFFF);
        rr_req = '0;
        tick();
        check_eq("rb_rdata_old", rr_rdata, 16'hC0DE);
        check_eq("rb_busy", rr_busy, 1);
        check_eq("rb_addr_hold", rr_address, 18'h3FFFF);
        rr_ready = 1'b1; rr_dr = 16'h1234;
        tick();
        check_eq("rb_done", rr_done, 3'b010);
        check_eq("rb_rdata", rr_rdata, 16'h1234);
        rr_ready = 1'b0;
        tick();

        // fixed priority with port mask
        fp_req = 2'b11; fp_en = 2'b10; fp_ready = 1'b1; fp_dr = 16'h0F0F;
        fp_addr[0 +: AW] = 18'h00111;
        fp_addr[AW +: AW] = 18'h00222;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq($sformatf("fpm_gnt%0d", k), fp_gnt, 1);
            check_eq($sformatf("fpm_addr%0d", k), fp_address, 18'h00222);
            tick();
            tick();
            check_eq($sformatf("fpm_done%0d", k), fp_done, 2'b10);
        end
        fp_en = 2'b11;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq($sformatf("fp_gnt%0d", k), fp_gnt, 0);
            check_eq($sformatf("fp_addr%0d", k), fp_address, 18'h00111);
            tick();
            tick();
            check_eq($sformatf("fp_done%0d", k), fp_done, 2'b01);
        end
        fp_req = '0; fp_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
